mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the program loader (w_en/machineCode path),
//  the MEM-stage data port and the IF-stage instruction fetch. One access is granted per cycle,
//  reads are pipelined with fixed latency, and stall_if/stall_mem go to the pipeline enables.
//  A drain/load FSM stops fetch and data traffic while a program is being written.
// PARAMETERS
//  AW          12  word-address width of the shared RAM
//  RD_LAT      1   RAM read latency in cycles (>=1); rdata is valid RD_LAT cycles after issue
//  STARVE_MAX  4   consecutive data grants with i_req pending before IF wins once; 0 = strict data priority
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  ld_req     in   1   loader write request; held until ld_gnt
//  ld_addr    in   AW  loader word address
//  ld_wdata   in   32  loader write data (full word)
//  ld_gnt     out  1   loader access issued this cycle
//  d_req      in   1   MEM-stage access request; held until d_gnt
//  d_we       in   1   1 = store, 0 = load
//  d_be       in   4   store byte enables
//  d_addr     in   AW  data word address
//  d_wdata    in   32  store data
//  d_gnt      out  1   data access issued this cycle
//  d_rvalid   out  1   load data valid on d_rdata
//  d_rdata    out  32  load data
//  i_req      in   1   fetch request; held until i_gnt
//  i_addr     in   AW  fetch word address
//  i_gnt      out  1   fetch issued this cycle
//  i_rvalid   out  1   instruction valid on i_rdata
//  i_rdata    out  32  instruction word
//  mem_en     out  1   RAM access strobe
//  mem_we     out  1   RAM write
//  mem_be     out  4   RAM byte enables
//  mem_addr   out  AW  RAM address
//  mem_wdata  out  32  RAM write data
//  mem_rdata  in   32  RAM read data, RD_LAT cycles after a read strobe
//  stall_if   out  1   i_req & ~i_gnt
//  stall_mem  out  1   d_req & ~d_gnt
// BEHAVIOUR
//  - Reset: state=RUN, streak=0, in-flight pipe cleared; every gnt, rvalid, mem_en, mem_we = 0.
//    Reset mid-read discards that read: no rvalid is issued for it after rst_n rises.
//  - Grants are combinational in the request cycle; at most one gnt per cycle. mem_* are driven
//    combinationally from the granted requester; mem_en=0, mem_we=0, mem_be=0 when nothing is granted.
//  - FSM: RUN   : ld_req & pipe empty -> LOAD; ld_req & pipe busy -> DRAIN; otherwise arbitrate i/d.
//         DRAIN : no grants; -> LOAD the cycle after the pipe becomes empty.
//         LOAD  : ld_gnt=ld_req, mem_we=1, mem_be=4'hF; i/d never granted; -> RUN when ld_req=0.
//  - RUN arbitration: data beats fetch unless streak==STARVE_MAX (STARVE_MAX!=0) and i_req=1;
//    then fetch wins. streak+1 on d_gnt while i_req=1; cleared on i_gnt or i_req=0; saturates at STARVE_MAX.
//  - Read tracking: RD_LAT-deep shift register of {valid, is_data}, loaded on every read grant
//    (IF always reads; data reads when d_we=0). Tail entry drives i_rvalid/d_rvalid. Writes carry no rvalid.
//    Reads may issue every cycle; responses return in issue order.
//  - i_rdata = d_rdata = mem_rdata; the value is meaningful only while the matching rvalid is 1.
//  - Simultaneous ld_req with i_req/d_req in RUN: ld_req wins the FSM change; i/d get no grant that cycle.
// TESTING
//  1 Assert rst_n=0 one cycle after an i_gnt read (RD_LAT=2) -> all outputs 0; i_rvalid never pulses.
//  2 STARVE_MAX=2, i_req and d_req held at cycle 0 -> d_gnt in cycles 0,1; i_gnt in cycle 2;
//    d_gnt in cycle 3; stall_if=1 in cycles 0-1.
//  3 RD_LAT=1, i_gnt at cycle t with i_addr=0x010, RAM word 0xDEADBEEF -> i_rvalid=1,
//    i_rdata=0xDEADBEEF at t+1.
//  4 RD_LAT=1, ld_req in the cycle after an i_gnt read -> state DRAIN for 1 cycle; ld_gnt then every
//    cycle with ld_req; i/d blocked; ld_req=0 -> RUN, i_gnt in the next cycle.
//  5 Store d_we=1, d_be=4'b0011, d_addr=0x004, d_wdata=0x0000ABCD -> mem_we=1, mem_be=0011; d_rvalid stays 0.
//  6 i_req held for 8 cycles with addrs 0..7 -> 8 consecutive i_rvalid pulses in address order.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the program loader, the MEM-stage data port
// and IF-stage fetch; tracks in-flight reads so responses are steered back in issue order.
module mem_port_arbiter #(
   parameter int AW         = 12,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ld_req,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_wdata,
   output logic          ld_gnt,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [3:0]    d_be,
   input  logic [AW-1:0] d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_gnt,
   output logic          i_rvalid,
   output logic [31:0]   i_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          stall_if,
   output logic          stall_mem
);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

   state_t            state;
   logic [SW-1:0]     streak;
   logic [RD_LAT-1:0] pipe_v;
   logic [RD_LAT-1:0] pipe_d;
   logic              pipe_busy;
   logic              run_arb;
   logic              i_win;
   logic              rd_issue;

   assign pipe_busy = |pipe_v;

   // Grants are gated by rst_n so nothing is issued while reset is asserted.
   assign run_arb = rst_n && (state == RUN) && !ld_req;
   assign i_win   = i_req && (!d_req || ((STARVE_MAX != 0) && (streak == STARVE_LIM)));
   assign ld_gnt  = rst_n && (state == LOAD) && ld_req;
   assign i_gnt   = run_arb && i_win;
   assign d_gnt   = run_arb && d_req && !i_win;

   assign stall_if  = i_req && !i_gnt;
   assign stall_mem = d_req && !d_gnt;
   assign rd_issue  = i_gnt || (d_gnt && !d_we);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'h0;
      mem_addr  = '0;
      mem_wdata = 32'h0;
      if (ld_gnt) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_be    = 4'hF;
         mem_addr  = ld_addr;
         mem_wdata = ld_wdata;
      end else if (d_gnt) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_be    = d_we ? d_be : 4'hF;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end else if (i_gnt) begin
         mem_en    = 1'b1;
         mem_be    = 4'hF;
         mem_addr  = i_addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         streak <= '0;
      end else begin
         case (state)
            RUN:     if (ld_req) state <= pipe_busy ? DRAIN : LOAD;
            DRAIN:   if (!pipe_busy) state <= LOAD;
            LOAD:    if (!ld_req) state <= RUN;
            default: state <= RUN;
         endcase
         if (i_gnt || !i_req)
            streak <= '0;
         else if (d_gnt && (streak != STARVE_LIM))
            streak <= streak + 1'b1;
      end
   end

   // Read-tracking shift register: stage 0 captures each read grant, the tail steers rvalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v[0] <= 1'b0;
         pipe_d[0] <= 1'b0;
      end else begin
         pipe_v[0] <= rd_issue;
         pipe_d[0] <= d_gnt;
      end
   end

   generate
      for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pipe_v[gi] <= 1'b0;
               pipe_d[gi] <= 1'b0;
            end else begin
               pipe_v[gi] <= pipe_v[gi-1];
               pipe_d[gi] <= pipe_d[gi-1];
            end
         end
      end
   endgenerate

   assign i_rvalid = pipe_v[RD_LAT-1] && !pipe_d[RD_LAT-1];
   assign d_rvalid = pipe_v[RD_LAT-1] &&  pipe_d[RD_LAT-1];
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle RAM model; read responses are checked
// against a queue of expected words filled when each read grant is issued.
module tb_mem_port_arbiter;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ld_req, d_req, d_we, i_req;
   logic [AW-1:0] ld_addr, d_addr, i_addr;
   logic [31:0]   ld_wdata, d_wdata;
   logic [3:0]    d_be;
   logic          ld_gnt, d_gnt, d_rvalid, i_gnt, i_rvalid;
   logic [31:0]   d_rdata, i_rdata;
   logic          mem_en, mem_we;
   logic [3:0]    mem_be;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;
   logic          stall_if, stall_mem;

   typedef struct packed {
      logic        is_data;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] ram [0:(1<<AW)-1];
   logic [31:0] got;

   mem_port_arbiter #(.AW(AW), .RD_LAT(1), .STARVE_MAX(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clk = ~clk;

   // Single-port RAM with byte-enabled writes and a registered read.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= ram[mem_addr];
         end
      end
   end

   // Response monitor: every rvalid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (i_rvalid || d_rvalid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL rsp_unexpected: i_rvalid=%0b d_rvalid=%0b, required no response", i_rvalid, d_rvalid);
         end else begin
            e   = sb.pop_front();
            got = e.is_data ? d_rdata : i_rdata;
            if (d_rvalid !== e.is_data || i_rvalid === e.is_data || got !== e.data) begin
               n_bad++;
               $display("FAIL rsp_data: i_rvalid=%0b d_rvalid=%0b rdata=%08h, required is_data=%0b rdata=%08h",
                        i_rvalid, d_rvalid, got, e.is_data, e.data);
            end else begin
               $display("rsp %s data=%08h ok", e.is_data ? "data" : "inst", got);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, required %08h", name, act, exp);
      end
   endtask

   task automatic push(input logic is_data, input logic [31:0] data);
      sb.push_back('{is_data: is_data, data: data});
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      ld_req = 0; d_req = 0; d_we = 0; i_req = 1;
      ld_addr = '0; d_addr = '0; i_addr = '0; ld_wdata = '0; d_wdata = '0; d_be = 4'h0;
      mem_rdata = '0;
      for (int a = 0; a < (1<<AW); a++) ram[a] = 32'h0;
      ram[0] = 32'h0BAD_F00D;
      d_req = 1;

      // Reset state with requests pending: nothing may be granted.
      repeat (2) @(posedge clk);
      #3;
      chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
      $display("txn reset checked");
      cyc();
      rst_n = 1; i_req = 0; d_req = 0;

      // Fetch, then loader request the next cycle: RUN -> DRAIN -> LOAD.
      cyc(); i_req = 1; i_addr = 12'h000; #2;
      chk("pre_ld_i_gnt", {31'b0, i_gnt}, 32'd1);
      push(1'b0, 32'h0BAD_F00D);
      $display("txn fetch addr=000");
      cyc(); ld_req = 1; ld_addr = 12'h000; ld_wdata = 32'h1000_0000; d_req = 1; d_we = 0; #2;
      chk("ldrun_ld_gnt", {31'b0, ld_gnt}, 32'd0);
      chk("ldrun_i_gnt", {31'b0, i_gnt}, 32'd0);
      chk("ldrun_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("ldrun_stalls", {30'b0, stall_if, stall_mem}, 32'd3);
      cyc(); #2;
      chk("drain_ld_gnt", {31'b0, ld_gnt}, 32'd0);
      chk("drain_mem_en", {31'b0, mem_en}, 32'd0);
      for (int k = 0; k < 9; k++) begin
         cyc();
         ld_addr  = (k < 8) ? AW'(k) : 12'h010;
         ld_wdata = (k < 8) ? 32'h1000_0000 + 32'(k) : 32'hDEAD_BEEF;
         #2;
         chk("load_ld_gnt", {31'b0, ld_gnt}, 32'd1);
         chk("load_mem_we", {31'b0, mem_we}, 32'd1);
         chk("load_mem_be", {28'b0, mem_be}, 32'hF);
         chk("load_mem_addr", {20'b0, mem_addr}, {20'b0, ld_addr});
         chk("load_id_blocked", {30'b0, i_gnt, d_gnt}, 32'd0);
         $display("txn load addr=%03h data=%08h", ld_addr, ld_wdata);
      end
      cyc(); ld_req = 0; d_req = 0; i_addr = 12'h010; #2;
      chk("ld_exit_i_gnt", {31'b0, i_gnt}, 32'd0);
      chk("ld_exit_ld_gnt", {31'b0, ld_gnt}, 32'd0);

      // Fetch the loaded word at 0x010.
      cyc(); #2;
      chk("run_i_gnt", {31'b0, i_gnt}, 32'd1);
      push(1'b0, 32'hDEAD_BEEF);
      $display("txn fetch addr=010");
      cyc(); i_req = 0; #2;
      chk("fetch_rvalid", {31'b0, i_rvalid}, 32'd1);

      // Back-to-back fetches 0..7.
      for (int k = 0; k < 8; k++) begin
         cyc(); i_req = 1; i_addr = AW'(k); #2;
         chk("burst_i_gnt", {31'b0, i_gnt}, 32'd1);
         if (k > 0) chk("burst_i_rvalid", {31'b0, i_rvalid}, 32'd1);
         push(1'b0, 32'h1000_0000 + 32'(k));
         $display("txn fetch addr=%03h", i_addr);
      end
      cyc(); i_req = 0; #2;
      chk("burst_last_rvalid", {31'b0, i_rvalid}, 32'd1);

      // Partial store: low halfword only.
      cyc(); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 12'h004; d_wdata = 32'h0000_ABCD; #2;
      chk("st_d_gnt", {31'b0, d_gnt}, 32'd1);
      chk("st_mem_we", {31'b0, mem_we}, 32'd1);
      chk("st_mem_be", {28'b0, mem_be}, 32'h3);
      chk("st_mem_addr", {20'b0, mem_addr}, 32'h004);
      chk("st_mem_wdata", mem_wdata, 32'h0000_ABCD);
      $display("txn store addr=004 be=0011 data=0000abcd");
      cyc(); d_req = 0; #2;
      chk("st_no_rvalid", {31'b0, d_rvalid}, 32'd0);

      // Starvation: data, data, fetch, data.
      cyc(); i_req = 1; i_addr = 12'h005; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 12'h004;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) cyc();
         #2;
         chk("starve_d_gnt", {31'b0, d_gnt}, (c == 2) ? 32'd0 : 32'd1);
         chk("starve_i_gnt", {31'b0, i_gnt}, (c == 2) ? 32'd1 : 32'd0);
         chk("starve_stall_if", {31'b0, stall_if}, (c == 2) ? 32'd0 : 32'd1);
         chk("starve_stall_mem", {31'b0, stall_mem}, (c == 2) ? 32'd1 : 32'd0);
         if (c == 2) push(1'b0, 32'h1000_0005);
         else        push(1'b1, 32'h1000_ABCD);
         $display("txn arb cycle %0d", c);
      end
      cyc(); i_req = 0; d_req = 0;
      cyc();

      // Reset while a fetch is in flight: its response must be dropped.
      cyc(); i_req = 1; i_addr = 12'h010; #2;
      chk("mid_i_gnt", {31'b0, i_gnt}, 32'd1);
      #1 rst_n = 0;
      #1;
      chk("mid_rst_gnts", {29'b0, i_gnt, d_gnt, ld_gnt}, 32'd0);
      chk("mid_rst_mem", {30'b0, mem_en, mem_we}, 32'd0);
      chk("mid_rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
      $display("txn reset mid-read");
      cyc(); i_req = 0; rst_n = 1;
      repeat (3) cyc();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
